// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: 10-bit frames in, read bytes out.
// Optional `ADDR_AUTO_INC_EN enables post-increment of both address registers for burst access.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam logic [ADDR_SIZE:0] DEPTH_W  = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(TX_HOLD - 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rx_valid_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [7:0]             mem_q [MEM_DEPTH];

  logic                   accept_s;
  logic [1:0]             cmd_s;
  logic [ADDR_SIZE-1:0]   payload_addr_s;
  logic                   mem_we_s;
  logic [7:0]             rd_word_s;

  function automatic logic addr_in_range(input logic [ADDR_SIZE-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

`ifdef ADDR_AUTO_INC_EN
  localparam logic [ADDR_SIZE:0] LAST_W = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] addr);
    if ({1'b0, addr} == LAST_W) begin
      return '0;
    end else begin
      return addr + ADDR_SIZE'(1);
    end
  endfunction
`endif

  // Only the rising edge of rx_valid accepts a frame; a held level is ignored.
  assign accept_s       = rx_valid & ~rx_valid_q;
  assign cmd_s          = rx_data[9:8];
  assign payload_addr_s = ADDR_SIZE'(rx_data[7:0]);
  assign rd_word_s      = addr_in_range(rd_addr_q) ? mem_q[MEM_AW'(rd_addr_q)] : 8'h00;
  assign tx_data        = tx_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      if (cmd_s == CMD_RD_DATA) begin
        state_d = TX_BUSY;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        TX_BUSY: begin
          if (cnt_q == '0) begin
            state_d = TX_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        TX_IDLE: state_d = TX_IDLE;
        default: begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tx_valid = (state_q == TX_BUSY);
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    tx_data_d = tx_data_q;
    mem_we_s  = 1'b0;
    if (accept_s) begin
      case (cmd_s)
        CMD_WR_ADDR: wr_addr_d = payload_addr_s;
        CMD_WR_DATA: begin
          mem_we_s = addr_in_range(wr_addr_q);
`ifdef ADDR_AUTO_INC_EN
          wr_addr_d = addr_inc(wr_addr_q);
`endif
        end
        CMD_RD_ADDR: rd_addr_d = payload_addr_s;
        CMD_RD_DATA: begin
          tx_data_d = rd_word_s;
`ifdef ADDR_AUTO_INC_EN
          rd_addr_d = addr_inc(rd_addr_q);
`endif
        end
        default: mem_we_s = 1'b0;
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array storage is intentionally unreset; out-of-range writes never assert mem_we_s.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[MEM_AW'(wr_addr_q)] <= rx_data[7:0];
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed plus randomized checking of spi_ram_ctrl (depth 256 and depth 200 instances)
// against a word-level reference model; honours `ADDR_AUTO_INC_EN.
module tb_spi_ram_ctrl;

  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data256, tx_data200;
  logic       tx_valid256, tx_valid200;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(HOLD)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data256), .tx_valid(tx_valid256)
  );

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .TX_HOLD(HOLD)) u_dut200 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data200), .tx_valid(tx_valid200)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: index 0 is the 256-word RAM, index 1 the 200-word RAM.
  int         depth [2] = '{256, 200};
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  logic [7:0] m_wr [2];
  logic [7:0] m_rd [2];
  logic [7:0] m_tx [2];
  bit         m_txk [2];
  int         busy_left;
  bit         prev_valid;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_wr[b]  = 8'h00;
      m_rd[b]  = 8'h00;
      m_tx[b]  = 8'h00;
      m_txk[b] = 1'b1;
    end
    busy_left  = 0;
    prev_valid = 1'b0;
  endtask

  function automatic logic [7:0] next_addr(input logic [7:0] a, input int d);
    if (int'(a) == d - 1) return 8'h00;
    return a + 8'd1;
  endfunction

  task automatic model_cmd(input logic [1:0] cmd, input logic [7:0] pay);
    for (int b = 0; b < 2; b++) begin
      case (cmd)
        2'd0: m_wr[b] = pay;
        2'd1: begin
          if (int'(m_wr[b]) < depth[b]) begin
            m_mem[b][m_wr[b]]   = pay;
            m_known[b][m_wr[b]] = 1'b1;
          end
`ifdef ADDR_AUTO_INC_EN
          m_wr[b] = next_addr(m_wr[b], depth[b]);
`endif
        end
        2'd2: m_rd[b] = pay;
        default: begin
          if (int'(m_rd[b]) < depth[b]) begin
            m_tx[b]  = m_mem[b][m_rd[b]];
            m_txk[b] = m_known[b][m_rd[b]];
          end else begin
            m_tx[b]  = 8'h00;
            m_txk[b] = 1'b1;
          end
`ifdef ADDR_AUTO_INC_EN
          m_rd[b] = next_addr(m_rd[b], depth[b]);
`endif
        end
      endcase
    end
    busy_left = (cmd == 2'd3) ? HOLD : 0;
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc        = rx_valid && !prev_valid && rst_n;
    prev_valid = rx_valid && rst_n;
    if (acc) model_cmd(rx_data[9:8], rx_data[7:0]);
    else if (busy_left > 0) busy_left--;
    #1;
    chk("valid256", {7'b0, tx_valid256}, {7'b0, (busy_left > 0)});
    chk("valid200", {7'b0, tx_valid200}, {7'b0, (busy_left > 0)});
    if (m_txk[0]) chk("data256", tx_data256, m_tx[0]);
    if (m_txk[1]) chk("data200", tx_data200, m_tx[1]);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] pay, input int hold);
    rx_data  = {cmd, pay};
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  int         hi;
  logic [1:0] rc;
  logic [7:0] rp;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld256", {7'b0, tx_valid256}, 8'h00);
    chk("rst_vld200", {7'b0, tx_valid200}, 8'h00);
    chk("rst_data256", tx_data256, 8'h00);
    chk("rst_data200", tx_data200, 8'h00);
    rst_n = 1'b1;
    tick();

    // Basic write then read with hold-length measurement.
    send(2'd0, 8'h12, 1);
    send(2'd1, 8'hA5, 1);
    send(2'd2, 8'h12, 1);
    rx_data  = {2'd3, 8'h00};
    rx_valid = 1'b1;
    hi = 0;
    tick();
    if (tx_valid256) hi++;
    chk("rd_a5", tx_data256, 8'hA5);
    rx_valid = 1'b0;
    repeat (13) begin
      tick();
      if (tx_valid256) hi++;
    end
    chk("hold_len", 8'(hi), 8'd10);
    chk("hold_data", tx_data256, 8'hA5);

    // Long rx_valid level must write only once.
    send(2'd0, 8'h05, 1);
    send(2'd1, 8'h3C, 15);
    send(2'd0, 8'h06, 1);
    send(2'd1, 8'h5A, 1);
    send(2'd2, 8'h05, 1);
    send(2'd3, 8'h00, 1);
    chk("level_3c", tx_data256, 8'h3C);
    send(2'd2, 8'h06, 1);
    send(2'd3, 8'h00, 1);
    chk("level_5a", tx_data256, 8'h5A);

    // Non-read command drops tx_valid; back-to-back RD_DATA reloads.
    send(2'd0, 8'h07, 1);
    send(2'd1, 8'h99, 1);
    send(2'd0, 8'h08, 1);
    send(2'd1, 8'h99, 1);
    send(2'd2, 8'h06, 1);
    send(2'd3, 8'h00, 1);
    send(2'd2, 8'h07, 1);
    chk("drop_vld", {7'b0, tx_valid256}, 8'h00);
    send(2'd3, 8'h00, 1);
    tick();
    tick();
    rx_data  = {2'd3, 8'h00};
    rx_valid = 1'b1;
    hi = 0;
    tick();
    if (tx_valid256) hi++;
    chk("reload_99", tx_data256, 8'h99);
    rx_valid = 1'b0;
    repeat (13) begin
      tick();
      if (tx_valid256) hi++;
    end
    chk("reload_len", 8'(hi), 8'd10);

    // Out-of-range access on the 200-word instance.
    send(2'd0, 8'hF0, 1);
    send(2'd1, 8'h77, 1);
    send(2'd2, 8'hF0, 1);
    send(2'd3, 8'h00, 1);
    chk("oor200_data", tx_data200, 8'h00);
    chk("oor200_vld", {7'b0, tx_valid200}, 8'h01);
    chk("in256_data", tx_data256, 8'h77);

    // Asynchronous reset in the middle of a transmit window.
    send(2'd0, 8'h00, 1);
    send(2'd1, 8'hC3, 1);
    send(2'd2, 8'h05, 1);
    send(2'd3, 8'h00, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld256", {7'b0, tx_valid256}, 8'h00);
    chk("arst_vld200", {7'b0, tx_valid200}, 8'h00);
    chk("arst_data256", tx_data256, 8'h00);
    chk("arst_data200", tx_data200, 8'h00);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(2'd3, 8'h00, 1);
    chk("post_rst256", tx_data256, 8'hC3);
    chk("post_rst200", tx_data200, 8'hC3);

    // Repeated WR_DATA at the top address.
    send(2'd0, 8'hFF, 1);
    send(2'd1, 8'h11, 1);
    send(2'd1, 8'h22, 1);
    send(2'd2, 8'hFF, 1);
    send(2'd3, 8'h00, 1);
`ifdef ADDR_AUTO_INC_EN
    chk("wrap_ff", tx_data256, 8'h11);
    send(2'd2, 8'h00, 1);
    send(2'd3, 8'h00, 1);
    chk("wrap_00", tx_data256, 8'h22);
`else
    chk("same_ff", tx_data256, 8'h22);
`endif

    // Randomized command stream against the model.
    for (int i = 0; i < 400; i++) begin
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rp = 8'($urandom_range(180, 255));
      else rp = 8'($urandom_range(0, 15));
      send(rc, rp, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 12)) tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port RAM with command decoder, directly downstream of the SPI slave. Consumes the slave's 10-bit frames (rx_data/rx_valid) and decodes bits [9:8] as commands: write address, write data, read address, read data. Returns read bytes to the slave on tx_data/tx_valid, which the slave serialises onto MISO.

Parameters:
MEM_DEPTH, 256, number of 8-bit words in the array
ADDR_SIZE, 8, width of the address field and the internal address registers (payload rx_data[7:0] is truncated/zero-extended to ADDR_SIZE)
TX_HOLD, 10, cycles tx_valid stays high after a read-data command (the SPI slave needs >= 9)

Ports:
clk       input   1   system clock, rising edge
rst_n     input   1   reset, asynchronous, active-low
rx_data   input   10  frame from the SPI slave: [9:8] command, [7:0] payload
rx_valid  input   1   frame valid from the SPI slave; may stay high for many cycles
tx_data   output  8   read data byte to the SPI slave
tx_valid  output  1   tx_data valid; held high TX_HOLD cycles

Behaviour:
- Reset (async, rst_n=0): tx_data=0, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_q=0, hold counter=0. Memory array is not reset; contents are undefined until written.
- Command acceptance is on the rx_valid rising edge only. A command is accepted at a posedge where rx_valid=1 and rx_valid_q=0. rx_valid_q is the registered rx_valid. A level held high does not re-trigger.
- Decode of an accepted command, on rx_data[9:8]:
  - 00 WR_ADDR: wr_addr <= payload.
  - 01 WR_DATA: mem[wr_addr] <= payload[7:0].
  - 10 RD_ADDR: rd_addr <= payload.
  - 11 RD_DATA: tx_data <= mem[rd_addr]; tx_valid <= 1; counter <= TX_HOLD-1. Payload is ignored (dummy byte).
- Latency: register updates, the memory write, tx_data and tx_valid are all registered at the accepting edge and visible in the following cycle. A WR_DATA followed by RD_ADDR and RD_DATA to the same address returns the new data.
- tx_valid FSM, two states:
  - TX_IDLE: tx_valid=0.
  - TX_BUSY: tx_valid=1. Counter decrements each cycle. At counter==0 the next edge returns to TX_IDLE (tx_valid low). Total high time is exactly TX_HOLD cycles.
- A command accepted while in TX_BUSY:
  - RD_DATA reloads tx_data and the counter and stays in TX_BUSY.
  - Any other command forces TX_IDLE at that edge.
- tx_data holds its last value after tx_valid falls. It changes only on RD_DATA.
- Out-of-range address (address >= MEM_DEPTH): WR_DATA is dropped (no write); RD_DATA returns 0x00 with normal tx_valid timing.
- Reset asserted mid-operation drops tx_valid immediately (asynchronous) and clears the address registers.
- Only one memory port is used. At most one read or one write happens per cycle by construction, because one command is accepted per edge.

Optional Feature:
ADDR_AUTO_INC_EN
- Defined: after each WR_DATA, wr_addr increments; after each RD_DATA, rd_addr increments. Both wrap from MEM_DEPTH-1 to 0. This enables burst access with a single address command.
- Undefined: addresses change only on WR_ADDR/RD_ADDR commands; repeated WR_DATA overwrites the same word.

Test Plan:
- Reset then WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA -> tx_data=0xA5 one cycle after the RD_DATA edge; tx_valid high exactly 10 cycles; then tx_valid=0 with tx_data still 0xA5.
- rx_valid held high 15 cycles carrying WR_DATA 0x3C at wr_addr 0x05, then 0x5A written to 0x06 via a fresh WR_ADDR/WR_DATA -> read back mem[0x05]=0x3C with no duplicate writes; exactly one write per rising edge.
- RD_DATA accepted, then a second RD_DATA (new rd_addr 0x07, holding 0x99) while tx_valid is still high -> tx_data=0x99 and the counter reloads; tx_valid stays high 10 cycles from the second accept.
- MEM_DEPTH=200: WR_ADDR 0xF0, WR_DATA 0x77, RD_ADDR 0xF0, RD_DATA -> tx_data=0x00, tx_valid asserted.
- rst_n pulsed low asynchronously mid-TX_BUSY (between clock edges) -> tx_valid=0 immediately and tx_data=0. After release, RD_DATA reads from address 0.
- With ADDR_AUTO_INC_EN: WR_ADDR 0xFF (MEM_DEPTH=256), WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap). Without the macro -> mem[0xFF]=0x22.
